// File: rtl/coin_collect_multi.sv
// Multi-channel coin collector/scorer: bird-vs-coin overlap, one-shot scoring with saturation, Start/Ack game FSM.
// Optional combo bonus is built when COIN_COMBO_EN is defined.
module coin_collect_multi #(
    parameter int NUM_COINS = 4,
    parameter int COORD_W   = 10,
    parameter int SCORE_W   = 10,
    parameter int COIN_H    = 20,
    parameter int COIN_VAL  = 1,
    parameter int COMBO_WIN = 64
) (
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           Start,
    input  logic                           Ack,
    input  logic [COORD_W-1:0]             Bird_X_L,
    input  logic [COORD_W-1:0]             Bird_X_R,
    input  logic [COORD_W-1:0]             Bird_Y_T,
    input  logic [COORD_W-1:0]             Bird_Y_B,
    input  logic [NUM_COINS*COORD_W-1:0]   Coin_X_L,
    input  logic [NUM_COINS*COORD_W-1:0]   Coin_X_R,
    input  logic [NUM_COINS*COORD_W-1:0]   Coin_Y,
    input  logic [NUM_COINS-1:0]           Coin_Valid,
    input  logic [NUM_COINS-1:0]           Coin_Respawn,
    output logic [NUM_COINS-1:0]           Hit,
    output logic [NUM_COINS-1:0]           Collected,
    output logic [SCORE_W-1:0]             Score,
    output logic                           Score_Pulse,
    output logic                           Score_Sat,
    output logic [2:0]                     Combo,
    output logic [1:0]                     State
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int                 PW         = $clog2(NUM_COINS + 1);
    localparam int                 SW1        = SCORE_W + 1;
    localparam logic [COORD_W:0]   COIN_H_EXT = COIN_H[COORD_W:0];
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t                 state_q, state_d;
    logic [NUM_COINS-1:0]   hit_q, coll_q, coll_d;
    logic [SCORE_W-1:0]     score_q, score_d, score_clamp_s;
    logic                   pulse_q, pulse_d, sat_q, sat_d;
    logic [2:0]             combo_q;
    logic [NUM_COINS-1:0]   ov_s, new_s;
    logic [PW-1:0]          pop_s;
    logic [SCORE_W:0]       pts_s, sum_s;
    logic                   run_s, clear_s;

    // Coin bottom edge is formed one bit wider so coins near the max coordinate do not wrap.
    for (genvar g = 0; g < NUM_COINS; g++) begin : g_ov
        logic [COORD_W-1:0] cxl_s, cxr_s, cy_s;
        logic [COORD_W:0]   cyb_s;
        logic               y_ok_s, x_ok_s;
        assign cxl_s  = Coin_X_L[g*COORD_W +: COORD_W];
        assign cxr_s  = Coin_X_R[g*COORD_W +: COORD_W];
        assign cy_s   = Coin_Y[g*COORD_W +: COORD_W];
        assign cyb_s  = {1'b0, cy_s} + COIN_H_EXT;
        assign y_ok_s = ((Bird_Y_B >= cy_s) && ({1'b0, Bird_Y_B} <= cyb_s)) ||
                        ((Bird_Y_T >= cy_s) && ({1'b0, Bird_Y_T} <= cyb_s));
        assign x_ok_s = (Bird_X_R > cxl_s) && (Bird_X_L < cxr_s);
        assign ov_s[g] = Coin_Valid[g] & y_ok_s & x_ok_s;
    end

    assign new_s = ov_s & ~hit_q & ~coll_q & ~Coin_Respawn;
    assign run_s = (state_q == S_RUN);

    // Count coins newly collected this cycle.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            pop_s = pop_s + PW'(new_s[i]);
        end
    end

    assign pts_s         = SW1'(pop_s) * SW1'(COIN_VAL) + SW1'(combo_q);
    assign sum_s         = {1'b0, score_q} + pts_s;
    assign score_clamp_s = sum_s[SCORE_W] ? SCORE_MAX : sum_s[SCORE_W-1:0];

    // Game FSM next state; entering RUN clears the round.
    always_comb begin
        state_d = state_q;
        clear_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    clear_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (Ack) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (Start) begin
                    state_d = S_RUN;
                    clear_s = 1'b1;
                end else if (Ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Score/collected next state; respawn wins over a same-cycle collection.
    always_comb begin
        score_d = score_q;
        coll_d  = coll_q;
        pulse_d = 1'b0;
        sat_d   = sat_q;
        if (clear_s) begin
            score_d = '0;
            coll_d  = '0;
            sat_d   = 1'b0;
        end else begin
            coll_d = (coll_q | (run_s ? new_s : '0)) & ~Coin_Respawn;
            if (run_s && (pop_s != '0)) begin
                score_d = score_clamp_s;
                pulse_d = 1'b1;
                sat_d   = (score_clamp_s == SCORE_MAX);
            end else begin
                score_d = score_q;
                pulse_d = 1'b0;
            end
        end
    end

    // Main state registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hit_q   <= '0;
            coll_q  <= '0;
            score_q <= '0;
            pulse_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= ov_s;
            coll_q  <= coll_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            sat_q   <= sat_d;
        end
    end

`ifdef COIN_COMBO_EN
    localparam int TW = $clog2(COMBO_WIN + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    combo_d;

    // Combo timer restarts on every scoring cycle; combo decays when it runs out.
    always_comb begin
        timer_d = timer_q;
        combo_d = combo_q;
        if (clear_s) begin
            timer_d = '0;
            combo_d = 3'd0;
        end else if (run_s && (pop_s != '0)) begin
            timer_d = TW'(COMBO_WIN);
            if (timer_q != '0) begin
                combo_d = (combo_q == 3'd7) ? 3'd7 : combo_q + 3'd1;
            end else begin
                combo_d = 3'd0;
            end
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
            combo_d = (timer_q == TW'(1)) ? 3'd0 : combo_q;
        end else begin
            timer_d = '0;
            combo_d = combo_q;
        end
    end

    // Combo registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            timer_q <= '0;
            combo_q <= 3'd0;
        end else begin
            timer_q <= timer_d;
            combo_q <= combo_d;
        end
    end
`else
    assign combo_q = 3'd0;
`endif

    assign Hit         = hit_q;
    assign Collected   = coll_q;
    assign Score       = score_q;
    assign Score_Pulse = pulse_q;
    assign Score_Sat   = sat_q;
    assign Combo       = combo_q;
    assign State       = state_q;

endmodule

// File: tb/tb_coin_collect_multi.sv
// Scoreboard bench for coin_collect_multi (default build, SCORE_W=4 so saturation is reachable).
module tb_coin_collect_multi;
    localparam int NC = 4;
    localparam int CW = 10;
    localparam int SW = 4;
    localparam int CH = 20;
    localparam int SMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, ack;
    logic [NC-1:0] cv, cr;
    int bxl, bxr, byt, byb;
    int cxl[NC], cxr[NC], cy[NC];
    logic [NC*CW-1:0] cxl_v, cxr_v, cy_v;
    logic [NC-1:0] hit_o, coll_o;
    logic [SW-1:0] score_o;
    logic pulse_o, sat_o;
    logic [2:0] combo_o;
    logic [1:0] state_o;

    always_comb begin
        cxl_v = '0; cxr_v = '0; cy_v = '0;
        for (int i = 0; i < NC; i++) begin
            cxl_v[i*CW +: CW] = cxl[i][CW-1:0];
            cxr_v[i*CW +: CW] = cxr[i][CW-1:0];
            cy_v[i*CW +: CW]  = cy[i][CW-1:0];
        end
    end

    coin_collect_multi #(.NUM_COINS(NC), .COORD_W(CW), .SCORE_W(SW), .COIN_H(CH),
                         .COIN_VAL(1), .COMBO_WIN(64)) dut (
        .Clk(clk), .reset(reset), .Start(start), .Ack(ack),
        .Bird_X_L(bxl[CW-1:0]), .Bird_X_R(bxr[CW-1:0]),
        .Bird_Y_T(byt[CW-1:0]), .Bird_Y_B(byb[CW-1:0]),
        .Coin_X_L(cxl_v), .Coin_X_R(cxr_v), .Coin_Y(cy_v),
        .Coin_Valid(cv), .Coin_Respawn(cr),
        .Hit(hit_o), .Collected(coll_o), .Score(score_o), .Score_Pulse(pulse_o),
        .Score_Sat(sat_o), .Combo(combo_o), .State(state_o));

    typedef struct {
        logic [NC-1:0] hit;
        logic [NC-1:0] coll;
        int score;
        bit pulse;
        bit sat;
        int state;
    } exp_t;
    exp_t sb[$];

    // reference model: game state 0 idle, 1 run, 2 done
    int m_state = 0;
    int m_score = 0;
    bit m_hit[NC];
    bit m_coll[NC];
    bit m_pulse = 0;
    bit m_sat = 0;
    int checks = 0;
    int errors = 0;

    function automatic bit overlaps(int i);
        bit y_ok, x_ok;
        y_ok = (byb >= cy[i] && byb <= cy[i] + CH) || (byt >= cy[i] && byt <= cy[i] + CH);
        x_ok = (bxr > cxl[i]) && (bxl < cxr[i]);
        return cv[i] && y_ok && x_ok;
    endfunction

    task automatic model_step();
        exp_t e;
        int n = 0;
        int ns;
        bit clr = 0;
        bit running;
        if (reset) begin
            m_state = 0; m_score = 0; m_pulse = 0; m_sat = 0;
            for (int i = 0; i < NC; i++) begin m_hit[i] = 0; m_coll[i] = 0; end
        end else begin
            running = (m_state == 1);
            ns = m_state;
            if (m_state == 0 && start) begin ns = 1; clr = 1; end
            else if (m_state == 1 && ack) ns = 2;
            else if (m_state == 2 && start) begin ns = 1; clr = 1; end
            else if (m_state == 2 && ack) ns = 0;
            for (int i = 0; i < NC; i++) begin
                bit o = overlaps(i);
                if (running && o && !m_hit[i] && !m_coll[i] && !cr[i]) begin
                    n++;
                    m_coll[i] = 1;
                end
                if (cr[i]) m_coll[i] = 0;
                m_hit[i] = o;
            end
            if (clr) begin
                m_score = 0; m_pulse = 0; m_sat = 0;
                for (int i = 0; i < NC; i++) m_coll[i] = 0;
            end else begin
                m_pulse = running && (n > 0);
                if (m_pulse) m_score = (m_score + n > SMAX) ? SMAX : m_score + n;
                m_sat = (m_score == SMAX);
            end
            m_state = ns;
        end
        for (int i = 0; i < NC; i++) begin
            e.hit[i] = m_hit[i];
            e.coll[i] = m_coll[i];
        end
        e.score = m_score; e.pulse = m_pulse; e.sat = m_sat; e.state = m_state;
        sb.push_back(e);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic run_n(int n);
        repeat (n) cycle();
    endtask

    task automatic bird(int xl, int yt);
        bxl = xl;
        bxr = (xl + 20 > 1023) ? 1023 : xl + 20;
        byt = yt;
        byb = (yt + 15 > 1023) ? 1023 : yt + 15;
    endtask

    task automatic respawn(logic [NC-1:0] m);
        cr = m; cycle(); cr = '0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: the DUT presents fresh outputs after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("hit", 32'(hit_o), 32'(e.hit));
                chk("collected", 32'(coll_o), 32'(e.coll));
                chk("score", 32'(score_o), e.score);
                chk("score_pulse", 32'(pulse_o), 32'(e.pulse));
                chk("score_sat", 32'(sat_o), 32'(e.sat));
                chk("combo", 32'(combo_o), 32'd0);
                chk("state", 32'(state_o), e.state);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; ack = 1'b0; cr = '0; cv = '0;
        bird(0, 200);
        for (int i = 0; i < NC; i++) begin cxl[i] = 110; cxr[i] = 130; cy[i] = 205; end
        run_n(2);
        reset = 1'b0; run_n(1);
        start = 1'b1; cycle(); start = 1'b0;
        // single pass over coin 0
        cv = 4'b0001;
        run_n(2); bird(100, 200); run_n(3); bird(0, 200); run_n(2);
        // parked, respawn while overlapping, then leave and return
        respawn(4'b0001);
        bird(100, 200); run_n(50);
        respawn(4'b0001); run_n(5);
        bird(0, 200); run_n(2); bird(100, 200); run_n(3); bird(0, 200); run_n(2);
        // three coins at once, then repeat until saturation
        cv = 4'b0111;
        repeat (6) begin
            respawn(4'b0111); bird(100, 200); run_n(2); bird(0, 200); run_n(1);
        end
        // edge boundaries: touching X edges, inclusive Y edges, coin near max Y
        respawn(4'b1111); bird(90, 200); run_n(2); bird(130, 200); run_n(2);
        bird(100, 190); run_n(2); bird(0, 0); run_n(1); bird(100, 225); run_n(2);
        bird(100, 226); run_n(2);
        cv = 4'b1000; cy[3] = 1015; bird(100, 1008); run_n(2); bird(0, 0); run_n(1);
        // Ack freezes, Start restarts, DONE->IDLE via Ack, Start beats Ack
        ack = 1'b1; cycle(); ack = 1'b0;
        cv = 4'b0111; cy[3] = 205; respawn(4'b0111); bird(100, 200); run_n(2); bird(0, 200);
        start = 1'b1; cycle(); start = 1'b0; run_n(2);
        start = 1'b1; cycle(); ack = 1'b1; start = 1'b0; cycle(); cycle();
        ack = 1'b0; run_n(1);
        start = 1'b1; cycle(); start = 1'b0; ack = 1'b1; cycle();
        start = 1'b1; cycle(); start = 1'b0; ack = 1'b0; run_n(2);
        // randomized play
        for (int k = 0; k < 1500; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 19) == 0);
            ack   = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NC; i++) begin
                cr[i] = ($urandom_range(0, 9) == 0);
                if (k % 8 == 0) begin
                    cv[i]  = ($urandom_range(0, 9) != 0);
                    cxl[i] = $urandom_range(100, 130);
                    cxr[i] = cxl[i] + $urandom_range(1, 25);
                    cy[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(995, 1023)
                                                          : $urandom_range(190, 230);
                end
            end
            if ($urandom_range(0, 1) == 0)
                bird($urandom_range(70, 150),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(990, 1023)
                                                 : $urandom_range(170, 240));
            cycle();
        end
        reset = 1'b0; start = 1'b0; ack = 1'b0; cr = '0;
        @(posedge clk); #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
